// File: rtl/branch_predict_unit.sv
// Branch direction predictor: 2-bit counter table read at fetch, trained at execute.
// Resolves B/BR conditions, raises a registered mispredict flush, keeps statistics.
module branch_predict_unit #(
  parameter int         PC_WIDTH    = 16,
  parameter int         BHT_ENTRIES = 16,
  parameter int         INDEX_LSB   = 1,
  parameter logic [1:0] INIT_STATE  = 2'b01,
  parameter int         CNT_WIDTH   = 16,
  parameter logic [3:0] B_OPCODE    = 4'hC,
  parameter logic [3:0] BR_OPCODE   = 4'hD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [PC_WIDTH-1:0]  if_pc,
  output logic                 if_pred_taken,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic [3:0]           ex_opcode,
  input  logic [2:0]           ex_cond,
  input  logic [2:0]           ex_flags,
  input  logic                 ex_pred_taken,
  output logic                 take_branch,
  output logic                 flush,
  output logic                 flush_taken,
  output logic [CNT_WIDTH-1:0] stat_branches,
  output logic [CNT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_ctr;
  logic [1:0]       ctr_next;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;
  logic             cond_met;
  logic             is_branch;
  logic             fire;
  logic             mis;
  logic             upd;
  logic             unused_pc;

  assign if_idx = if_pc[INDEX_LSB +: IDX_W];
  assign ex_idx = ex_pc[INDEX_LSB +: IDX_W];
  assign unused_pc = ^{if_pc, ex_pc};

  // Lookup sees the stored value; an update this cycle lands next cycle.
  assign if_pred_taken = if_valid & bht[if_idx][1];

  assign flag_z = ex_flags[2];
  assign flag_v = ex_flags[1];
  assign flag_n = ex_flags[0];

  always_comb begin
    cond_met = 1'b0;
    unique case (ex_cond)
      3'b000: cond_met = ~flag_z;
      3'b001: cond_met = flag_z;
      3'b010: cond_met = ~flag_z & ~flag_n;
      3'b011: cond_met = flag_n;
      3'b100: cond_met = flag_z | (~flag_z & ~flag_n);
      3'b101: cond_met = flag_n | flag_z;
      3'b110: cond_met = flag_v;
      3'b111: cond_met = 1'b1;
    endcase
  end

  assign is_branch = (ex_opcode == B_OPCODE) |
                     (ex_opcode == BR_OPCODE);
  assign take_branch = ex_valid & is_branch & cond_met;
  assign fire = ex_valid & ~ex_stall;
  assign mis = fire & (take_branch != ex_pred_taken);
  assign upd = fire & is_branch;

  assign ex_ctr = bht[ex_idx];

  always_comb begin
    ctr_next = ex_ctr;
    unique case (1'b1)
      take_branch & (ex_ctr != 2'b11):  ctr_next = ex_ctr + 2'd1;
      ~take_branch & (ex_ctr != 2'b00): ctr_next = ex_ctr - 2'd1;
      default:                          ctr_next = ex_ctr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= INIT_STATE;
      end
    end else if (upd) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush       <= 1'b0;
      flush_taken <= 1'b0;
    end else begin
      flush <= mis;
      if (mis) begin
        flush_taken <= take_branch;
      end
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd && (stat_branches != '1)) begin
        stat_branches <= stat_branches + CNT_WIDTH'(1);
      end
      if (mis && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a scoreboard of
// registered results (flush, flush_taken, statistics).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_stall;
  logic [15:0] ex_pc;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_cond;
  logic [2:0]  ex_flags;
  logic        ex_pred_taken;
  logic        take_branch;
  logic        flush;
  logic        flush_taken;
  logic [3:0]  stat_branches;
  logic [3:0]  stat_mispredicts;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid),
    .ex_stall(ex_stall),
    .ex_pc(ex_pc),
    .ex_opcode(ex_opcode),
    .ex_cond(ex_cond),
    .ex_flags(ex_flags),
    .ex_pred_taken(ex_pred_taken),
    .take_branch(take_branch),
    .flush(flush),
    .flush_taken(flush_taken),
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  typedef struct packed {
    logic       f;
    logic       ft;
    logic [3:0] br;
    logic [3:0] mi;
  } exp_t;

  exp_t       sbq[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [1:0] m_tab[16];
  int         m_br;
  int         m_mis;
  logic       m_ft;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tab[i] = 2'b01;
    m_br = 0;
    m_mis = 0;
    m_ft = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "/sbq_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "/flush"}, flush, e.f);
      chk({tag, "/flush_taken"}, flush_taken, e.ft);
      chk({tag, "/stat_br"}, stat_branches, e.br);
      chk({tag, "/stat_mis"}, stat_mispredicts, e.mi);
    end
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    e.f = 1'b0;
    e.ft = 1'b0;
    e.br = 4'd0;
    e.mi = 4'd0;
    sbq.push_back(e);
    check_regs("reset");
  endtask

  task automatic lookup(input string tag, input logic [15:0] pc,
                        input logic exp);
    if_valid = 1'b1;
    if_pc = pc;
    #1;
    chk(tag, if_pred_taken, exp);
  endtask

  task automatic ex_step(input string tag, input logic [3:0] op,
                         input logic [2:0] cc, input logic [2:0] fl,
                         input logic pred, input logic stall,
                         input logic [15:0] pc, input logic exp_take);
    exp_t e;
    int   idx;
    logic isb;
    logic fire;
    logic mis;
    ex_valid = 1'b1;
    ex_stall = stall;
    ex_pc = pc;
    ex_opcode = op;
    ex_cond = cc;
    ex_flags = fl;
    ex_pred_taken = pred;
    if_valid = 1'b1;
    if_pc = pc;
    #1;
    idx = int'((pc >> 1) & 16'h000F);
    chk({tag, "/take"}, take_branch, exp_take);
    chk({tag, "/pre_upd_pred"}, if_pred_taken, m_tab[idx][1]);
    isb = (op == 4'hC) || (op == 4'hD);
    fire = !stall;
    mis = fire && (exp_take != pred);
    if (fire && isb) begin
      if (exp_take && m_tab[idx] != 2'b11) m_tab[idx] = m_tab[idx] + 2'd1;
      if (!exp_take && m_tab[idx] != 2'b00) m_tab[idx] = m_tab[idx] - 2'd1;
      if (m_br < 15) m_br++;
    end
    if (mis) begin
      m_ft = exp_take;
      if (m_mis < 15) m_mis++;
    end
    e.f = mis;
    e.ft = m_ft;
    e.br = 4'(m_br);
    e.mi = 4'(m_mis);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_regs(tag);
    ex_valid = 1'b0;
    ex_stall = 1'b0;
    ex_pred_taken = 1'b0;
  endtask

  task automatic idle(input string tag);
    exp_t e;
    e.f = 1'b0;
    e.ft = m_ft;
    e.br = 4'(m_br);
    e.mi = 4'(m_mis);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_valid = 1'b0;
    if_pc = '0;
    ex_valid = 1'b0;
    ex_stall = 1'b0;
    ex_pc = '0;
    ex_opcode = '0;
    ex_cond = '0;
    ex_flags = '0;
    ex_pred_taken = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    for (int p = 0; p <= 16'h1E; p += 2) lookup("init_pred", 16'(p), 1'b0);
    if_valid = 1'b0;
    if_pc = 16'h0010;
    #1;
    chk("pred_if_invalid", if_pred_taken, 1'b0);

    ex_step("b1", 4'hC, 3'b001, 3'b100, 1'b0, 1'b0, 16'h0010, 1'b1);
    ex_step("b2", 4'hC, 3'b001, 3'b100, 1'b1, 1'b0, 16'h0010, 1'b1);
    ex_step("b3", 4'hC, 3'b001, 3'b100, 1'b1, 1'b0, 16'h0010, 1'b1);
    chk("b_stat_br", stat_branches, 4'd3);
    chk("b_stat_mis", stat_mispredicts, 4'd1);
    lookup("b_trained", 16'h0010, 1'b1);

    ex_step("c010_0", 4'hC, 3'b010, 3'b000, 1'b0, 1'b0, 16'h0002, 1'b1);
    ex_step("c010_n", 4'hD, 3'b010, 3'b001, 1'b0, 1'b0, 16'h0004, 1'b0);
    ex_step("c110_v", 4'hC, 3'b110, 3'b010, 1'b0, 1'b0, 16'h0006, 1'b1);
    ex_step("c111", 4'hD, 3'b111, 3'b111, 1'b0, 1'b0, 16'h0008, 1'b1);
    ex_step("c000_z", 4'hC, 3'b000, 3'b100, 1'b0, 1'b0, 16'h000A, 1'b0);
    ex_step("c011_n", 4'hC, 3'b011, 3'b001, 1'b0, 1'b0, 16'h000C, 1'b1);
    ex_step("c100_z", 4'hD, 3'b100, 3'b100, 1'b0, 1'b0, 16'h000E, 1'b1);
    ex_step("c101_0", 4'hC, 3'b101, 3'b000, 1'b0, 1'b0, 16'h0014, 1'b0);
    ex_step("c001_0", 4'hC, 3'b001, 3'b000, 1'b0, 1'b0, 16'h0016, 1'b0);
    chk("cm_stat_br", stat_branches, 4'd12);
    chk("cm_stat_mis", stat_mispredicts, 4'd6);

    ex_step("nonbr", 4'h0, 3'b111, 3'b111, 1'b1, 1'b0, 16'h001C, 1'b0);
    chk("nonbr_ft", flush_taken, 1'b0);
    chk("nonbr_br", stat_branches, 4'd12);
    ex_step("nonbr_b", 4'hC, 3'b111, 3'b000, 1'b0, 1'b0, 16'h001C, 1'b1);
    lookup("nonbr_tab", 16'h001C, 1'b1);

    ex_step("stall", 4'hC, 3'b111, 3'b000, 1'b0, 1'b1, 16'h0018, 1'b1);
    lookup("stall_tab", 16'h0018, 1'b0);
    ex_step("unstall", 4'hC, 3'b111, 3'b000, 1'b0, 1'b0, 16'h0018, 1'b1);
    chk("unstall_ft", flush_taken, 1'b1);
    idle("post_flush");
    lookup("unstall_tab", 16'h0018, 1'b1);

    lookup("alias_30", 16'h0030, 1'b1);
    for (int k = 0; k < 20; k++) begin
      ex_step("sat", 4'hC, 3'b111, 3'b000, m_tab[3][1], 1'b0,
              16'h0006, 1'b1);
    end
    chk("sat_br", stat_branches, 4'd15);

    ex_valid = 1'b1;
    ex_stall = 1'b0;
    ex_pc = 16'h001A;
    ex_opcode = 4'hC;
    ex_cond = 3'b111;
    ex_pred_taken = 1'b0;
    do_reset();
    ex_valid = 1'b0;
    for (int p = 0; p <= 16'h1E; p += 2) lookup("rst_pred", 16'(p), 1'b0);
    chk("rst_flush", flush, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
